// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the seven-segment scan controller.
//   SEG_BLANK / AN_OFF are the "everything dark" values for the active-low
//   segment and anode buses. CNT_W is the prescaler width for the default
//   refresh divider; the controller derives its own width from its
//   REFRESH_DIV parameter so other divider settings still fit.
//   DIG_W covers up to 8 digits.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK       = 8'hFF;
    localparam logic [7:0] AN_OFF          = 8'hFF;
    localparam int         REFRESH_DIV_DEF = 100000;
    localparam int         CNT_W           = $clog2(REFRESH_DIV_DEF);
    localparam int         DIG_W           = 3;

    // Active-low anode pattern that enables exactly one digit
    function automatic logic [7:0] anode_onehot(input logic [DIG_W-1:0] d);
        return ~(8'h01 << d);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hexto7seg.sv
// ---------------------------------------------------------------------------
// hexto7seg
//   Existing 4-bit hex to seven-segment decoder, active-low glyphs 0-F
//   (A, b, C, d, E, F). Bit 7 (decimal point) is always 1 (off); callers
//   that want a point override it themselves.
//   Ports:
//     hex  in  4  nibble to show
//     seg  out 8  {dp,g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hexto7seg (
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    // Pure lookup; the default arm keeps the block latch-free
    always_comb begin
        seg = 8'hFF;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit common-anode seven-
//   segment display. A 32-bit word (one nibble per digit) plus an 8-bit
//   decimal-point mask is written into a shadow register and only becomes
//   visible at the end of a full frame, so a frame never shows half of an
//   old word and half of a new one.
//
//   Optional feature macro: SEG7_LZ_BLANK_EN
//     When defined, leading zero digits (all higher nibbles zero, not digit
//     0) have their segments blanked; the anode still drives and the point
//     is still honoured.
//
//   Parameters:
//     NUM_DIGITS    digits scanned (1..8); digit i shows data[4i+3:4i]
//     REFRESH_DIV   clk cycles per digit slot (>= 2)
//     BLANK_CYCLES  dark cycles at the start of each slot (< REFRESH_DIV)
//   Ports:
//     clk         in   1   system clock
//     rst_n       in   1   asynchronous active-low reset
//     data_in     in   32  new display word
//     dp_in       in   8   new decimal-point mask, 1 = point lit
//     data_we     in   1   strobe: capture data_in/dp_in into the shadow
//     pending     out  1   shadow holds a word not yet shown
//     frame_done  out  1   one-cycle pulse as the last digit slot ends
//     an          out  8   anode enables, active-low, registered
//     seg         out 8   {dp,g..a}, active-low, registered
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        data_we,
    output logic        pending,
    output logic        frame_done,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int               CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]    BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [CW-1:0]    cnt;
    logic [DIG_W-1:0] digit;
    logic             tick;
    logic             commit;

    logic [31:0]      shown_data;
    logic [7:0]       shown_dp;
    logic [31:0]      shadow_data;
    logic [7:0]       shadow_dp;

    logic [3:0]       nibble;
    logic [7:0]       dec_seg;
    logic             dp_bit;
    logic             lz_blank;

    assign tick       = (cnt == CNT_LAST);
    assign commit     = tick && (digit == DIG_LAST);
    assign frame_done = commit;

    // Prescaler: one full count per digit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index advances once per slot and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (tick) begin
            digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
        end
    end

    // Shadow/commit: writes land in the shadow and are promoted only at the
    // frame boundary. A write arriving exactly on the boundary skips the
    // shadow stage and goes straight to the shown word, so nothing is left
    // pending behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_data  <= '0;
            shown_dp    <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            if (data_we) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            if (commit) begin
                pending <= 1'b0;
                if (data_we) begin
                    shown_data <= data_in;
                    shown_dp   <= dp_in;
                end else if (pending) begin
                    shown_data <= shadow_data;
                    shown_dp   <= shadow_dp;
                end
            end else if (data_we) begin
                pending <= 1'b1;
            end
        end
    end

    assign nibble = shown_data[{digit, 2'b00} +: 4];
    assign dp_bit = shown_dp[digit];

    hexto7seg u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Only nibbles that can actually be displayed count as "higher digits"
    localparam logic [31:0] LIVE_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                        : ((32'h1 << (4 * NUM_DIGITS)) - 32'h1);
    logic [31:0] upper;
    assign upper    = (shown_data & LIVE_MASK) >> {digit, 2'b00};
    assign lz_blank = (digit != '0) && (upper == 32'h0);
`else
    assign lz_blank = 1'b0;
`endif

    // Output registers: they reflect this cycle's cnt/digit one clock later.
    // The decoder's point bit is always 1, so ANDing it with the inverted
    // mask bit just yields the active-low point from the mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (cnt < BLANK_END) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= anode_onehot(digit);
            seg <= {~dp_bit & dec_seg[7], lz_blank ? 7'h7F : dec_seg[6:0]};
        end
    end

endmodule
